// File: rtl/pipe_pkg.sv
// Shared pipeline encodings for the hazard/interrupt controller.
package pipe_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PUSH_PC  = 2'd1,
        PUSH_CCR = 2'd2,
        VECTOR   = 2'd3
    } hz_state_t;

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_TGT  = 2'b01;
    localparam logic [1:0] PC_VEC  = 2'b10;
    localparam logic [1:0] PC_POP  = 2'b11;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [1:0] INJ_NONE = 2'b00;
    localparam logic [1:0] INJ_PC   = 2'b01;
    localparam logic [1:0] INJ_CCR  = 2'b10;

endpackage

// File: rtl/fwd_sel.sv
// Bypass-source select for one execute-stage operand; memory stage wins over write-back.
module fwd_sel
    import pipe_pkg::*;
#(
    parameter int REG_AW = 3
) (
    input  logic [REG_AW-1:0] opnd,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    output logic [1:0]        sel
);

    always_comb begin
        sel = FWD_RF;
        if (mem_reg_write && (mem_rd == opnd))
            sel = FWD_MEM;
        else if (wb_reg_write && (wb_rd == opnd))
            sel = FWD_WB;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall, control-transfer flush, operand forwarding and the
// interrupt entry sequence (push PC, push CCR, vector).
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] dec_rs,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              dec_uses_rs,
    input  logic              dec_uses_rd,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              mem_reg_write,
    input  logic              wb_reg_write,
    input  logic              branch_taken,
    input  logic              jump,
    input  logic              ret_wb,
    input  logic              int_req,
    output logic              fd_enable,
    output logic              fd_flush,
    output logic              de_bubble,
    output logic [1:0]        fwd_src_sel,
    output logic [1:0]        fwd_dst_sel,
    output logic [1:0]        pc_sel,
    output logic              inj_valid,
    output logic [1:0]        inj_op,
    output logic              int_ack,
    output logic [CNT_W-1:0]  stall_cnt
);

    hz_state_t state, state_n, st;
    logic      int_pending;
    logic      load_use;
    logic      xfer;

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_src (
        .opnd(ex_rs), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .sel(fwd_src_sel)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_dst (
        .opnd(ex_rd), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .sel(fwd_dst_sel)
    );

    assign load_use = ex_mem_read && ex_reg_write &&
                      ((dec_uses_rs && (dec_rs == ex_rd)) ||
                       (dec_uses_rd && (dec_rd == ex_rd)));
    assign xfer     = branch_taken || jump;

    // Outputs behave as IDLE while reset is held, before the register clears.
    assign st = reset ? IDLE : state;

    always_comb begin
        fd_enable = 1'b1;
        fd_flush  = 1'b0;
        de_bubble = 1'b0;
        pc_sel    = PC_SEQ;
        inj_valid = 1'b0;
        inj_op    = INJ_NONE;
        int_ack   = 1'b0;
        state_n   = st;

        if (st != VECTOR) begin
            if (ret_wb) begin
                pc_sel    = PC_POP;
                fd_flush  = 1'b1;
                de_bubble = 1'b1;
            end else if (xfer) begin
                pc_sel    = PC_TGT;
                fd_flush  = 1'b1;
                de_bubble = 1'b1;
            end else if (load_use && (st == IDLE)) begin
                fd_enable = 1'b0;
                de_bubble = 1'b1;
            end
        end

        case (st)
            IDLE: begin
                if ((int_pending || int_req) && !load_use && !xfer && !ret_wb)
                    state_n = PUSH_PC;
            end
            PUSH_PC, PUSH_CCR: begin
                // A redirect abandons the push; pending stays set so it restarts.
                if (xfer || ret_wb) begin
                    state_n = IDLE;
                end else begin
                    inj_valid = 1'b1;
                    fd_enable = 1'b0;
                    inj_op    = (st == PUSH_PC) ? INJ_PC : INJ_CCR;
                    state_n   = (st == PUSH_PC) ? PUSH_CCR : VECTOR;
                end
            end
            VECTOR: begin
                pc_sel    = PC_VEC;
                fd_flush  = 1'b1;
                de_bubble = 1'b1;
                int_ack   = 1'b1;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            int_pending <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state       <= state_n;
            int_pending <= int_req || (int_pending && (state != VECTOR));
            if (!fd_enable && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scenarios plus a randomized run against a rule-level reference model.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] dec_rs, dec_rd, ex_rs, ex_rd, mem_rd, wb_rd;
    logic       dec_uses_rs, dec_uses_rd, ex_mem_read, ex_reg_write;
    logic       mem_reg_write, wb_reg_write, branch_taken, jump, ret_wb, int_req;

    logic        fd_enable, fd_flush, de_bubble, inj_valid, int_ack;
    logic [1:0]  fwd_src_sel, fwd_dst_sel, pc_sel, inj_op;
    logic [15:0] stall_cnt;

    logic        s_fd_enable, s_fd_flush, s_de_bubble, s_inj_valid, s_int_ack;
    logic [1:0]  s_fwd_src_sel, s_fwd_dst_sel, s_pc_sel, s_inj_op;
    logic [3:0]  stall_cnt4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(3), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .dec_rs(dec_rs), .dec_rd(dec_rd), .dec_uses_rs(dec_uses_rs), .dec_uses_rd(dec_uses_rd),
        .ex_rs(ex_rs), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .branch_taken(branch_taken), .jump(jump), .ret_wb(ret_wb), .int_req(int_req),
        .fd_enable(fd_enable), .fd_flush(fd_flush), .de_bubble(de_bubble),
        .fwd_src_sel(fwd_src_sel), .fwd_dst_sel(fwd_dst_sel), .pc_sel(pc_sel),
        .inj_valid(inj_valid), .inj_op(inj_op), .int_ack(int_ack), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.REG_AW(3), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset),
        .dec_rs(dec_rs), .dec_rd(dec_rd), .dec_uses_rs(dec_uses_rs), .dec_uses_rd(dec_uses_rd),
        .ex_rs(ex_rs), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .branch_taken(branch_taken), .jump(jump), .ret_wb(ret_wb), .int_req(int_req),
        .fd_enable(s_fd_enable), .fd_flush(s_fd_flush), .de_bubble(s_de_bubble),
        .fwd_src_sel(s_fwd_src_sel), .fwd_dst_sel(s_fwd_dst_sel), .pc_sel(s_pc_sel),
        .inj_valid(s_inj_valid), .inj_op(s_inj_op), .int_ack(s_int_ack), .stall_cnt(stall_cnt4)
    );

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        {dec_rs, dec_rd, ex_rs, ex_rd, mem_rd, wb_rd} = '0;
        {dec_uses_rs, dec_uses_rd, ex_mem_read, ex_reg_write} = '0;
        {mem_reg_write, wb_reg_write, branch_taken, jump, ret_wb, int_req} = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset   = 1'b1;
        int_req = 1'b1;
        cyc();
        cyc();
        #1;
        n_tests++;
        if ({fd_enable, fd_flush, de_bubble, pc_sel, inj_valid, int_ack} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 1000000",
                     {fd_enable, fd_flush, de_bubble, pc_sel, inj_valid, int_ack});
        end
        n_tests++;
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
        end
        reset   = 1'b0;
        int_req = 1'b0;
        cyc();
        cyc();
        #1;
        n_tests++;
        if (inj_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discards_int: got inj_valid=%b expected 0", inj_valid);
        end
    endtask

    task automatic test_forward();
        clear_inputs();
        ex_rs = 3'd3; mem_rd = 3'd3; wb_rd = 3'd3; mem_reg_write = 1'b1; wb_reg_write = 1'b1;
        ex_rd = 3'd6;
        #1;
        n_tests++;
        if (fwd_src_sel !== 2'b01 || fwd_dst_sel !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_mem_priority: got src=%b dst=%b expected src=01 dst=00", fwd_src_sel, fwd_dst_sel);
        end
        mem_reg_write = 1'b0;
        #1;
        n_tests++;
        if (fwd_src_sel !== 2'b10) begin
            n_fail++;
            $display("FAIL fwd_wb: got %b expected 10", fwd_src_sel);
        end
        ex_rd = 3'd5; wb_rd = 3'd5; mem_rd = 3'd5; mem_reg_write = 1'b1;
        #1;
        n_tests++;
        if (fwd_dst_sel !== 2'b01 || fwd_src_sel !== 2'b00) begin
            n_fail++;
            $display("FAIL fwd_dst: got dst=%b src=%b expected dst=01 src=00", fwd_dst_sel, fwd_src_sel);
        end
        clear_inputs();
    endtask

    task automatic test_load_use();
        clear_inputs();
        #1;
        n_tests++;
        if (stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL lu_cnt_before: got %0d expected 0", stall_cnt);
        end
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 3'd2; dec_rs = 3'd2; dec_uses_rs = 1'b1;
        #1;
        n_tests++;
        if ({fd_enable, de_bubble, fd_flush, pc_sel} !== 5'b01000) begin
            n_fail++;
            $display("FAIL lu_stall: got %b expected 01000", {fd_enable, de_bubble, fd_flush, pc_sel});
        end
        cyc();
        clear_inputs();
        #1;
        n_tests++;
        if (stall_cnt !== 16'd1 || fd_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL lu_cnt_after: got cnt=%0d fe=%b expected cnt=1 fe=1", stall_cnt, fd_enable);
        end
    endtask

    task automatic test_interrupt();
        clear_inputs();
        int_req = 1'b1;
        #1;
        n_tests++;
        if (inj_valid !== 1'b0 || fd_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL int_req_cycle: got iv=%b fe=%b expected iv=0 fe=1", inj_valid, fd_enable);
        end
        cyc();
        int_req = 1'b0;
        #1;
        n_tests++;
        if ({inj_valid, inj_op, fd_enable, de_bubble} !== 5'b10100) begin
            n_fail++;
            $display("FAIL int_push_pc: got %b expected 10100", {inj_valid, inj_op, fd_enable, de_bubble});
        end
        cyc();
        #1;
        n_tests++;
        if ({inj_valid, inj_op, fd_enable} !== 4'b1100) begin
            n_fail++;
            $display("FAIL int_push_ccr: got %b expected 1100", {inj_valid, inj_op, fd_enable});
        end
        cyc();
        #1;
        n_tests++;
        if ({int_ack, pc_sel, fd_flush, de_bubble, inj_valid} !== 6'b110110) begin
            n_fail++;
            $display("FAIL int_vector: got %b expected 110110", {int_ack, pc_sel, fd_flush, de_bubble, inj_valid});
        end
        cyc();
        #1;
        n_tests++;
        if ({int_ack, inj_valid, pc_sel} !== 4'b0000) begin
            n_fail++;
            $display("FAIL int_done: got %b expected 0000", {int_ack, inj_valid, pc_sel});
        end
        cyc();
        #1;
        n_tests++;
        if (inj_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL int_cleared: got inj_valid=%b expected 0", inj_valid);
        end
    endtask

    task automatic test_abort();
        clear_inputs();
        int_req = 1'b1;
        cyc();
        int_req = 1'b0;
        cyc();
        branch_taken = 1'b1;
        #1;
        n_tests++;
        if ({pc_sel, inj_valid, fd_flush, de_bubble, fd_enable} !== 6'b010111) begin
            n_fail++;
            $display("FAIL abort_ccr: got %b expected 010111", {pc_sel, inj_valid, fd_flush, de_bubble, fd_enable});
        end
        cyc();
        branch_taken = 1'b0;
        #1;
        n_tests++;
        if (inj_valid !== 1'b0 || fd_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_idle: got iv=%b fe=%b expected iv=0 fe=1", inj_valid, fd_enable);
        end
        cyc();
        #1;
        n_tests++;
        if ({inj_valid, inj_op} !== 3'b101) begin
            n_fail++;
            $display("FAIL abort_restart: got %b expected 101", {inj_valid, inj_op});
        end
        cyc();
        cyc();
        #1;
        n_tests++;
        if (int_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_vector: got int_ack=%b expected 1", int_ack);
        end
        cyc();
    endtask

    task automatic test_ret_and_reset();
        clear_inputs();
        ret_wb = 1'b1; branch_taken = 1'b1;
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; dec_uses_rs = 1'b1;
        #1;
        n_tests++;
        if ({pc_sel, fd_flush, de_bubble, fd_enable} !== 5'b11111) begin
            n_fail++;
            $display("FAIL ret_priority: got %b expected 11111", {pc_sel, fd_flush, de_bubble, fd_enable});
        end
        cyc();
        clear_inputs();
        int_req = 1'b1;
        cyc();
        int_req = 1'b0;
        reset   = 1'b1;
        #1;
        n_tests++;
        if (inj_valid !== 1'b0 || fd_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_push: got iv=%b fe=%b expected iv=0 fe=1", inj_valid, fd_enable);
        end
        cyc();
        reset = 1'b0;
        #1;
        n_tests++;
        if (inj_valid !== 1'b0 || stall_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_mid_seq: got iv=%b cnt=%0d expected iv=0 cnt=0", inj_valid, stall_cnt);
        end
        cyc();
        #1;
        n_tests++;
        if (inj_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pending_cleared: got iv=%b expected 0", inj_valid);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 3'd4; dec_rd = 3'd4; dec_uses_rd = 1'b1;
        repeat (20) cyc();
        clear_inputs();
        #1;
        n_tests++;
        if (stall_cnt4 !== 4'd15 || stall_cnt !== 16'd20) begin
            n_fail++;
            $display("FAIL stall_saturate: got cnt4=%0d cnt16=%0d expected 15 and 20", stall_cnt4, stall_cnt);
        end
        cyc();
        #1;
        n_tests++;
        if (stall_cnt4 !== 4'd15) begin
            n_fail++;
            $display("FAIL stall_hold: got %0d expected 15", stall_cnt4);
        end
    endtask

    // Reference model: phase 0 idle, 1/2 pushing (phase == injected op code), 3 vector.
    task automatic test_random();
        int          phase;
        bit          pend;
        int          cnt;
        bit          lu, redirect;
        logic        e_fe, e_fl, e_bub, e_iv, e_ack;
        logic [1:0]  e_fs, e_fd, e_pc, e_io;
        logic [28:0] exp_v, got_v;
        do_reset();
        phase = 0; pend = 0; cnt = 0;
        for (int i = 0; i < 500; i++) begin
            dec_rs = 3'($urandom_range(0, 7)); dec_rd = 3'($urandom_range(0, 7));
            ex_rs  = 3'($urandom_range(0, 7)); ex_rd  = 3'($urandom_range(0, 7));
            mem_rd = 3'($urandom_range(0, 7)); wb_rd  = 3'($urandom_range(0, 7));
            dec_uses_rs   = 1'($urandom_range(0, 1));
            dec_uses_rd   = 1'($urandom_range(0, 1));
            ex_mem_read   = ($urandom_range(0, 2) == 0);
            ex_reg_write  = ($urandom_range(0, 3) != 0);
            mem_reg_write = 1'($urandom_range(0, 1));
            wb_reg_write  = 1'($urandom_range(0, 1));
            branch_taken  = ($urandom_range(0, 9) == 0);
            jump          = ($urandom_range(0, 19) == 0);
            ret_wb        = ($urandom_range(0, 19) == 0);
            int_req       = ($urandom_range(0, 5) == 0);
            #1;
            lu = ex_mem_read && ex_reg_write &&
                 ((dec_uses_rs && dec_rs == ex_rd) || (dec_uses_rd && dec_rd == ex_rd));
            redirect = branch_taken || jump || ret_wb;
            e_fs = (mem_reg_write && mem_rd == ex_rs) ? 2'd1 : (wb_reg_write && wb_rd == ex_rs) ? 2'd2 : 2'd0;
            e_fd = (mem_reg_write && mem_rd == ex_rd) ? 2'd1 : (wb_reg_write && wb_rd == ex_rd) ? 2'd2 : 2'd0;
            e_fe = 1; e_fl = 0; e_bub = 0; e_pc = 0; e_iv = 0; e_io = 0; e_ack = 0;
            if (phase == 3) begin
                e_pc = 2; e_fl = 1; e_bub = 1; e_ack = 1;
            end else if (redirect) begin
                e_pc = ret_wb ? 2'd3 : 2'd1; e_fl = 1; e_bub = 1;
            end else if (phase != 0) begin
                e_iv = 1; e_io = 2'(phase); e_fe = 0;
            end else if (lu) begin
                e_fe = 0; e_bub = 1;
            end
            exp_v = {e_fe, e_fl, e_bub, e_fs, e_fd, e_pc, e_iv, e_io, e_ack, 16'(cnt)};
            got_v = {fd_enable, fd_flush, de_bubble, fwd_src_sel, fwd_dst_sel, pc_sel,
                     inj_valid, inj_op, int_ack, stall_cnt};
            n_tests++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h expected %h (phase %0d)", i, got_v, exp_v, phase);
            end
            if (!e_fe && cnt < 65535) cnt++;
            case (phase)
                0:       phase = ((pend || int_req) && !lu && !redirect) ? 1 : 0;
                1, 2:    phase = redirect ? 0 : phase + 1;
                default: phase = 0;
            endcase
            pend = int_req || (pend && e_ack == 0);
            cyc();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #1;
        test_reset();
        test_forward();
        test_load_use();
        test_interrupt();
        test_abort();
        test_ret_and_reset();
        test_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 3, register-address width (2**REG_AW architectural registers).
REQ-002 Parameter CNT_W, default 16, stall-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 dec_rs, dec_rd  input  REG_AW each  source/destination register addresses in decode.
REQ-006 dec_uses_rs, dec_uses_rd  input  1 each  decode instruction reads that operand.
REQ-007 ex_rs, ex_rd  input  REG_AW each  operand addresses in execute.
REQ-008 ex_mem_read, ex_reg_write  input  1 each  execute-stage load and write-back flags.
REQ-009 mem_rd, wb_rd  input  REG_AW each  destination addresses in memory and write-back.
REQ-010 mem_reg_write, wb_reg_write  input  1 each  write-enable flags for those stages.
REQ-011 branch_taken, jump  input  1 each  control-transfer resolved in execute.
REQ-012 ret_wb  input  1  PC pop (RET/RTI) reaches write-back.
REQ-013 int_req  input  1  external interrupt request, one-cycle pulse or level.
REQ-014 fd_enable  output  1  fetch/decode register load enable.
REQ-015 fd_flush, de_bubble  output  1 each  clear fetch/decode register; force NOP control word into decode/execute register.
REQ-016 fwd_src_sel, fwd_dst_sel  output  2 each  00 register file, 01 memory-stage result, 10 write-back data.
REQ-017 pc_sel  output  2  00 sequential, 01 branch/jump target, 10 interrupt vector, 11 popped PC.
REQ-018 inj_valid, inj_op  output  1, 2  inject micro-op into decode/execute: 01 push PC, 10 push CCR.
REQ-019 int_ack  output  1  one-cycle pulse on vector taken.
REQ-020 stall_cnt  output  CNT_W  count of cycles with fd_enable=0.

Function
REQ-021 Forwarding: fwd_src_sel=01 when mem_reg_write and mem_rd==ex_rs, else 10 when wb_reg_write and wb_rd==ex_rs, else 00; dst identical on ex_rd; memory stage has priority.
REQ-022 Load-use: load_use=ex_mem_read & ex_reg_write & ((dec_uses_rs & dec_rs==ex_rd) | (dec_uses_rd & dec_rd==ex_rd)); when set: fd_enable=0, de_bubble=1, pc_sel=00, PC held, same cycle (combinational).
REQ-023 branch_taken|jump: pc_sel=01, fd_flush=1, de_bubble=1; overrides load_use.
REQ-024 ret_wb: pc_sel=11, fd_flush=1, de_bubble=1; overrides branch/jump and load_use.
REQ-025 int_pending register sets on any cycle with int_req=1; cleared only in VECTOR; further requests while pending merge (single pending).
REQ-026 FSM states IDLE, PUSH_PC, PUSH_CCR, VECTOR, registered.
REQ-027 IDLE -> PUSH_PC when int_pending and none of load_use, branch_taken, jump, ret_wb this cycle.
REQ-028 PUSH_PC: inj_valid=1, inj_op=01, fd_enable=0, de_bubble=0; next PUSH_CCR.
REQ-029 PUSH_CCR: inj_valid=1, inj_op=10, fd_enable=0; next VECTOR.
REQ-030 VECTOR: pc_sel=10, fd_flush=1, de_bubble=1, int_ack=1; clear int_pending (unless int_req=1 same cycle); next IDLE.
REQ-031 branch_taken, jump or ret_wb in PUSH_PC/PUSH_CCR: that control transfer executes per REQ-023/024, inj_valid=0, FSM -> IDLE, int_pending retained; sequence restarts from PUSH_PC.
REQ-032 Interrupt latency from int_req (IDLE, no hazards) to int_ack: exactly 3 cycles after the sampling edge.
REQ-033 Default outputs: fd_enable=1, all others 0.
REQ-034 stall_cnt increments by 1 each cycle fd_enable=0, saturates at all-ones.

Reset
REQ-035 reset=1 at an edge: state=IDLE, int_pending=0, stall_cnt=0; takes effect mid-sequence, no injection follows.
REQ-036 While reset=1, combinational outputs follow IDLE rules; int_req during reset is discarded.

Structure
REQ-037 State encoding, pc_sel, fwd_sel and inj_op codes are localparams in the shared pipeline package pipe_pkg.
REQ-038 Forwarding comparison is one sub-module fwd_sel instantiated twice (src, dst).

Verification
REQ-039 mem_rd=ex_rs=3, mem_reg_write=1, wb_rd=3, wb_reg_write=1 -> fwd_src_sel=01; drop mem_reg_write -> 10.
REQ-040 ex_mem_read=1, ex_reg_write=1, ex_rd=2, dec_rs=2, dec_uses_rs=1 -> one cycle fd_enable=0, de_bubble=1, stall_cnt 0->1.
REQ-041 int_req pulse in IDLE -> PUSH_PC, PUSH_CCR, VECTOR on next 3 cycles; int_ack and pc_sel=10 in the third.
REQ-042 branch_taken=1 during PUSH_CCR -> pc_sel=01, inj_valid=0, FSM IDLE, then PUSH_PC next cycle.
REQ-043 ret_wb=1 with branch_taken=1 -> pc_sel=11; reset asserted in PUSH_PC -> IDLE, int_pending=0, stall_cnt=0.
REQ-044 CNT_W=4, 20 stall cycles -> stall_cnt=15 held.
